spi_shift_master: RTL and testbench

Mode-0 SPI master shift engine, downstream of the clock divider. It consumes the divider's registered output as a bit-rate reference inside the fast clock domain and builds a serial transaction from it. The transaction covers chip select, serial clock, MOSI and MISO. All logic runs on one clock; the reference is used only through edge detection, never as a clock.

---
 rtl/spi_shift_master.sv | 133 +++++++++++++
 tb/tb_spi_shift_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_master.sv
// Mode-0 SPI master shift engine. It is paced by edges of a divided reference
// (sclk_src_i) that is sampled in the clk_i domain and is never used as a clock.
`timescale 1ns/1ps
module spi_shift_master #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              sclk_src_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              miso_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cs_n_o,
  output logic              sclk_o,
  output logic              mosi_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, FINISH} state_e;

  state_e              state_q, state_d;
  logic                src_q;
  logic                rise_c, fall_c;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;

  // Reference edges; a stalled reference yields no edges, so the FSM simply holds.
  assign rise_c = sclk_src_i & ~src_q;
  assign fall_c = ~sclk_src_i & src_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= sclk_src_i;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          tx_sr_d   = tx_data_i;
          mosi_d    = tx_data_i[DATA_W-1];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = ALIGN;
        end
      end
      // First fall guarantees a full low half-period of MOSI setup.
      ALIGN: begin
        if (fall_c) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rise_c) begin
          sclk_d    = 1'b1;
          rx_sr_d   = {rx_sr_q[DATA_W-2:0], miso_i};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else if (fall_c) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == CNT_W'(DATA_W)) begin
            state_d = FINISH;
          end else begin
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_sr_q[DATA_W-2];
          end
        end
      end
      FINISH: begin
        rx_data_d = rx_sr_q;
        done_d    = 1'b1;
        cs_n_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cs_n_o    = cs_n_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_shift_master.sv
// Bench for spi_shift_master: divider model with period 10, a word-level SPI
// slave (loopback or fixed reply word) and directed plus random transfers.
`timescale 1ns/1ps
module tb_spi_shift_master;

  localparam int DW     = 8;
  localparam int P      = 10;
  localparam int MAXLAT = P + DW * P + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          div_rst;
  logic          sclk_src_i;
  logic          start_i;
  logic [DW-1:0] tx_data_i;
  logic          miso_i;
  logic [DW-1:0] rx_data_o;
  logic          busy_o, done_o, cs_n_o, sclk_o, mosi_o;

  int total = 0;
  int bad   = 0;
  int div_cnt;

  // Slave-side view of the bus: counts SCLK edges and collects the MOSI word.
  logic          loopback   = 1'b1;
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] slave_rx   = '0;
  logic          prev_sclk  = 1'b0;
  logic          slave_bit;
  int            rises      = 0;
  int            falls      = 0;
  int            done_cnt   = 0;

  spi_shift_master #(.DATA_W(DW)) dut (
    .clk_i      (clk),
    .rst        (rst),
    .sclk_src_i (sclk_src_i),
    .start_i    (start_i),
    .tx_data_i  (tx_data_i),
    .miso_i     (miso_i),
    .rx_data_o  (rx_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cs_n_o     (cs_n_o),
    .sclk_o     (sclk_o),
    .mosi_o     (mosi_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge div_rst) begin
    if (div_rst) begin
      div_cnt    <= 0;
      sclk_src_i <= 1'b0;
    end else begin
      div_cnt    <= (div_cnt == P - 1) ? 0 : div_cnt + 1;
      sclk_src_i <= (div_cnt >= P / 2);
    end
  end

  assign slave_bit = (falls < DW) ? slave_word[3'(DW - 1 - falls)] : 1'b0;
  assign miso_i    = loopback ? mosi_o : slave_bit;

  always begin
    @(posedge clk);
    #1;
    if (!prev_sclk && sclk_o) begin
      rises++;
      slave_rx = {slave_rx[DW-2:0], mosi_o};
    end
    if (prev_sclk && !sclk_o) falls++;
    if (done_o) done_cnt++;
    prev_sclk = sclk_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // hook: 0 none, 1 second start at hook_at, 2 reset at hook_at, 3 divider stall at hook_at
  task automatic xfer(input logic [DW-1:0] tx, input logic lb, input logic [DW-1:0] sw,
                      input int hook, input int hook_at, input logic b2b);
    int            cyc;
    int            w;
    int            changes;
    int            snap_r;
    logic          snap_s, snap_m, snap_c;
    logic [DW-1:0] exp_rx;
    exp_rx     = lb ? tx : sw;
    loopback   = lb;
    slave_word = sw;
    rises      = 0;
    falls      = 0;
    slave_rx   = '0;
    done_cnt   = 0;
    start_i    = 1'b1;
    tx_data_i  = tx;
    @(negedge clk);
    start_i   = 1'b0;
    tx_data_i = DW'($urandom);
    cyc       = 1;
    chk("accept_busy", 32'(busy_o), 32'd1);
    chk("accept_cs_n", 32'(cs_n_o), 32'd0);
    chk("accept_mosi", 32'(mosi_o), 32'(tx[DW-1]));
    chk("accept_done", 32'(done_o), 32'd0);
    while (!done_o && cyc < 400) begin
      start_i = (hook == 1 && cyc == hook_at);
      if (start_i) tx_data_i = '1;
      if (hook == 2 && cyc == hook_at) begin
        rst = 1'b1;
        #1;
        chk("rst_cs_n", 32'(cs_n_o), 32'd1);
        chk("rst_sclk", 32'(sclk_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mosi", 32'(mosi_o), 32'd0);
        chk("rst_rx", 32'(rx_data_o), 32'd0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        repeat (120) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_rx_after", 32'(rx_data_o), 32'd0);
        chk("rst_idle_busy", 32'(busy_o), 32'd0);
        return;
      end
      if (hook == 3 && cyc == hook_at) begin
        w = 0;
        while (!(sclk_src_i == 1'b0 && sclk_o == 1'b0) && w < 50) begin
          @(negedge clk);
          cyc++;
          w++;
        end
        div_rst = 1'b1;
        snap_s  = sclk_o;
        snap_m  = mosi_o;
        snap_c  = cs_n_o;
        snap_r  = rises;
        changes = 0;
        repeat (50) begin
          @(negedge clk);
          cyc++;
          if (sclk_o !== snap_s || mosi_o !== snap_m || cs_n_o !== snap_c) changes++;
        end
        chk("stall_frozen", 32'(changes), 32'd0);
        chk("stall_bits", 32'(rises), 32'(snap_r));
        chk("stall_busy", 32'(busy_o), 32'd1);
        div_rst = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    if (!done_o) begin
      chk("done_timeout", 32'(done_o), 32'd1);
      return;
    end
    chk("rx_word", 32'(rx_data_o), 32'(exp_rx));
    chk("mosi_word", 32'(slave_rx), 32'(tx));
    chk("sclk_rises", 32'(rises), 32'(DW));
    chk("done_busy", 32'(busy_o), 32'd0);
    chk("done_cs_n", 32'(cs_n_o), 32'd1);
    if (hook != 3) chk("latency", 32'(cyc <= MAXLAT), 32'd1);
    if (!b2b) begin
      @(negedge clk);
      chk("done_pulse", 32'(done_o), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] tx, sw;
    logic          lb, bb;
    rst       = 1'b1;
    div_rst   = 1'b1;
    start_i   = 1'b0;
    tx_data_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_rx", 32'(rx_data_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_cs_n", 32'(cs_n_o), 32'd1);
    chk("reset_sclk", 32'(sclk_o), 32'd0);
    chk("reset_mosi", 32'(mosi_o), 32'd0);
    rst     = 1'b0;
    div_rst = 1'b0;
    repeat (4) @(negedge clk);

    xfer(8'hA5, 1'b1, 8'h00, 0, 0, 1'b0);
    chk("loop_one_done", 32'(done_cnt), 32'd1);
    repeat (3) @(negedge clk);

    xfer(8'h00, 1'b0, 8'hFF, 0, 0, 1'b0);
    repeat (3) @(negedge clk);

    xfer(8'h3C, 1'b0, 8'h96, 1, 20, 1'b0);
    repeat (20) @(negedge clk);
    chk("restart_one_done", 32'(done_cnt), 32'd1);
    chk("restart_idle", 32'(busy_o), 32'd0);

    xfer(8'h5A, 1'b1, 8'h00, 2, 30, 1'b0);
    xfer(8'hC3, 1'b1, 8'h00, 0, 0, 1'b0);
    repeat (2) @(negedge clk);

    xfer(8'h81, 1'b1, 8'h00, 0, 0, 1'b1);
    chk("b2b_gap_cs_n", 32'(cs_n_o), 32'd1);
    xfer(8'h7E, 1'b1, 8'h00, 0, 0, 1'b0);
    repeat (2) @(negedge clk);

    xfer(8'h6B, 1'b0, 8'hD2, 3, 30, 1'b0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      tx = DW'($urandom);
      sw = DW'($urandom);
      lb = 1'($urandom_range(0, 1));
      bb = ($urandom_range(0, 3) == 0);
      xfer(tx, lb, sw, 0, 0, bb);
      if (!bb) repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
